// File: rtl/kugelblitz_offload_arb.sv
// ---------------------------------------------------------------------------
// kugelblitz_offload_arb
//   Packet-level round-robin arbiter sharing one kugelblitz offload datapath
//   between two AXI-stream requesters. A grant is held for a whole frame and
//   each frame is tagged with its source on m_axis_tdest.
//
// Ports
//   clk, rst_n            sole clock (rising edge), async active-low reset
//   s0_axis_*             requester 0 stream (tready is an output)
//   s1_axis_*             requester 1 stream (tready is an output)
//   m_axis_*              stream to the offload engine (tready is an input)
//   m_axis_tdest          index of the granted source
//   cfg_enable[1:0]       per-port enable, gates new grants only
//   busy                  high while a frame is in flight
//   pkt_count0/1          frames forwarded per port, wrapping
// ---------------------------------------------------------------------------
module kugelblitz_offload_arb #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic                  s0_axis_tlast,
  input  logic [USER_WIDTH-1:0] s0_axis_tuser,

  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic                  s1_axis_tlast,
  input  logic [USER_WIDTH-1:0] s1_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tdest,

  input  logic [1:0]            cfg_enable,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_count0,
  output logic [CNT_WIDTH-1:0]  pkt_count1
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  logic [1:0]           req;
  logic                 winner;
  logic                 frame_end;

  // Eligible requests; the enable mask only matters while arbitrating.
  assign req = {s1_axis_tvalid & cfg_enable[1], s0_axis_tvalid & cfg_enable[0]};

  // Contention goes to the port opposite the previous grant; otherwise the
  // single requester wins (req[1] selects port 1 when it is the only one).
  assign winner = (req == 2'b11) ? ~last_grant_q : req[1];

  assign frame_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold the grant until the tlast handshake.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (state_q == IDLE) begin
      if (|req) begin
        grant_d      = winner;
        last_grant_d = winner;
        state_d      = GRANT;
      end
    end else begin
      if (frame_end) begin
        state_d = IDLE;
        if (grant_q) begin
          cnt1_d = cnt1_q + CNT_WIDTH'(1);
        end else begin
          cnt0_d = cnt0_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Zero-latency passthrough from the granted port; everything quiet in IDLE.
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = '0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (state_q == GRANT) begin
      if (grant_q) begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tuser   = s1_axis_tuser;
        s1_axis_tready = m_axis_tready;
      end else begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tuser   = s0_axis_tuser;
        s0_axis_tready = m_axis_tready;
      end
    end
  end

  assign m_axis_tdest = grant_q;
  assign busy         = (state_q == GRANT);
  assign pkt_count0   = cnt0_q;
  assign pkt_count1   = cnt1_q;

endmodule

// File: tb/tb_kugelblitz_offload_arb.sv
// ---------------------------------------------------------------------------
// tb_kugelblitz_offload_arb
//   Directed bench: reset defaults, fairness, enable mask, mask change
//   mid-frame, backpressure with gaps, counter wrap (narrow instance) and
//   asynchronous reset mid-frame. Inputs change on the falling edge and
//   outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_kugelblitz_offload_arb;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          u;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data  [2];
  logic [KW-1:0] s_keep  [2];
  logic          s_valid [2];
  logic          s_ready [2];
  logic          s_last  [2];
  logic          s_user  [2];

  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          m_user;
  logic          m_tdest;
  logic [1:0]    cfg_en;
  logic          busy;
  logic [31:0]   cnt0, cnt1;

  kugelblitz_offload_arb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s0_axis_tdata  (s_data[0]),
    .s0_axis_tkeep  (s_keep[0]),
    .s0_axis_tvalid (s_valid[0]),
    .s0_axis_tready (s_ready[0]),
    .s0_axis_tlast  (s_last[0]),
    .s0_axis_tuser  (s_user[0]),
    .s1_axis_tdata  (s_data[1]),
    .s1_axis_tkeep  (s_keep[1]),
    .s1_axis_tvalid (s_valid[1]),
    .s1_axis_tready (s_ready[1]),
    .s1_axis_tlast  (s_last[1]),
    .s1_axis_tuser  (s_user[1]),
    .m_axis_tdata   (m_data),
    .m_axis_tkeep   (m_keep),
    .m_axis_tvalid  (m_valid),
    .m_axis_tready  (m_ready),
    .m_axis_tlast   (m_last),
    .m_axis_tuser   (m_user),
    .m_axis_tdest   (m_tdest),
    .cfg_enable     (cfg_en),
    .busy           (busy),
    .pkt_count0     (cnt0),
    .pkt_count1     (cnt1)
  );

  // Narrow instance used to reach counter wrap quickly.
  logic       w_valid = 1'b0;
  logic       w_s0_ready, w_s1_ready, w_m_valid, w_m_last, w_m_tdest, w_busy;
  logic [7:0] w_m_data;
  logic [0:0] w_m_keep, w_m_user;
  logic [1:0] w_cnt0, w_cnt1;

  kugelblitz_offload_arb #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1), .CNT_WIDTH(2)) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .s0_axis_tdata  (8'h00),
    .s0_axis_tkeep  (1'b0),
    .s0_axis_tvalid (1'b0),
    .s0_axis_tready (w_s0_ready),
    .s0_axis_tlast  (1'b0),
    .s0_axis_tuser  (1'b0),
    .s1_axis_tdata  (8'h5A),
    .s1_axis_tkeep  (1'b1),
    .s1_axis_tvalid (w_valid),
    .s1_axis_tready (w_s1_ready),
    .s1_axis_tlast  (1'b1),
    .s1_axis_tuser  (1'b0),
    .m_axis_tdata   (w_m_data),
    .m_axis_tkeep   (w_m_keep),
    .m_axis_tvalid  (w_m_valid),
    .m_axis_tready  (1'b1),
    .m_axis_tlast   (w_m_last),
    .m_axis_tuser   (w_m_user),
    .m_axis_tdest   (w_m_tdest),
    .cfg_enable     (2'b10),
    .busy           (w_busy),
    .pkt_count0     (w_cnt0),
    .pkt_count1     (w_cnt1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard state
  beat_t exp_q0[$];
  beat_t exp_q1[$];
  int    tdest_log[$];
  int    cyc      = 0;
  int    hs_cnt   = 0;
  int    last_end = -1;
  bit    gap_chk  = 1'b0;
  bit    in_frame = 1'b0;
  bit    cur_src  = 1'b0;
  bit    abort    = 1'b0;
  bit    rdy_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready: steady high or random backpressure.
  initial forever begin
    @(negedge clk);
    m_ready = rdy_rand ? ($urandom_range(0, 99) < 60) : 1'b1;
  end

  function automatic logic [DW-1:0] pat(input int p, input int f, input int b);
    logic [DW-1:0] r;
    for (int l = 0; l < 8; l++)
      r[64*l +: 64] = {8'(l), 8'(p), 16'(f), 16'(b), 16'hA5C3 ^ 16'(b * 7 + f)};
    return r;
  endfunction

  function automatic logic [KW-1:0] keep_of(input int n);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[i] = 1'b1;
    return k;
  endfunction

  // Drive one frame of len bytes on port p; gap is the per-beat idle chance in %.
  task automatic send_frame(input int p, input int f, input int len, input int gap);
    beat_t fr[$];
    beat_t bt;
    int    nb;
    nb = (len + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      bt.d = pat(p, f, b);
      bt.k = keep_of((b == nb - 1) ? len - 64 * b : 64);
      bt.u = 1'((b + p) % 2);
      bt.l = (b == nb - 1);
      fr.push_back(bt);
      if (p == 0) exp_q0.push_back(bt); else exp_q1.push_back(bt);
    end
    for (int b = 0; b < nb; b++) begin
      bit done;
      int waited;
      if (abort) break;
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        s_valid[p] = 1'b0;
        @(negedge clk);
      end
      s_valid[p] = 1'b1;
      s_data[p]  = fr[b].d;
      s_keep[p]  = fr[b].k;
      s_user[p]  = fr[b].u;
      s_last[p]  = fr[b].l;
      done   = 1'b0;
      waited = 0;
      while (!done && !abort) begin
        #1;
        done = s_ready[p];
        @(negedge clk);
        waited++;
        if (waited > 3000) begin
          chk($sformatf("src%0d_stall", p), 64'(waited), 64'd3000);
          abort = 1'b1;
        end
      end
    end
    s_valid[p] = 1'b0;
    s_last[p]  = 1'b0;
  endtask

  task automatic wait_hs(input int n);
    int base;
    int c;
    base = hs_cnt;
    c    = 0;
    while (hs_cnt < base + n && c < 5000) begin
      @(negedge clk); #2;
      c++;
    end
    if (c >= 5000) chk("hs_timeout", 64'(hs_cnt - base), 64'(n));
  endtask

  task automatic wait_cnt1(input int n);
    int c;
    c = 0;
    while (cnt1 != 32'(n) && c < 5000) begin
      @(negedge clk); #2;
      c++;
    end
    if (c >= 5000) chk("cnt1_timeout", 64'(cnt1), 64'(n));
  endtask

  // Output monitor: per-port in-order compare, interleave and gap checks.
  initial forever begin
    @(negedge clk); #1;
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (m_valid && m_ready) begin
      beat_t e;
      bit    have;
      hs_cnt++;
      if (in_frame) begin
        chk("no_interleave", 64'(m_tdest), 64'(cur_src));
      end else begin
        tdest_log.push_back(int'(m_tdest));
        if (gap_chk && last_end >= 0) chk("ifg", 64'(cyc - last_end), 64'd2);
      end
      have = 1'b0;
      if (m_tdest) begin
        chk("exp1_avail", 64'(exp_q1.size() != 0), 64'd1);
        if (exp_q1.size() != 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      end else begin
        chk("exp0_avail", 64'(exp_q0.size() != 0), 64'd1);
        if (exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      end
      if (have) begin
        chk("data", 64'(m_data == e.d), 64'd1);
        chk("keep", m_keep, e.k);
        chk("user", 64'(m_user), 64'(e.u));
        chk("last", 64'(m_last), 64'(e.l));
      end
      cur_src  = m_tdest;
      in_frame = !m_last;
      if (m_last) last_end = cyc;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    cfg_en = 2'b11;
    for (int i = 0; i < 2; i++) begin
      s_data[i] = '0; s_keep[i] = '0; s_valid[i] = 1'b0; s_last[i] = 1'b0; s_user[i] = 1'b0;
    end

    // Reset defaults
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last",  64'(m_last),  64'd0);
    chk("rst_m_data",  64'(m_data == '0), 64'd1);
    chk("rst_tdest",   64'(m_tdest), 64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_rdy0",    64'(s_ready[0]), 64'd0);
    chk("rst_rdy1",    64'(s_ready[1]), 64'd0);
    chk("rst_cnt0",    64'(cnt0), 64'd0);
    chk("rst_cnt1",    64'(cnt1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: both ports offer ten 3-beat frames from the first cycle
    gap_chk  = 1'b1;
    last_end = -1;
    tdest_log.delete();
    fork
      for (int i = 0; i < 10; i++) send_frame(0, i, 192, 0);
      for (int i = 0; i < 10; i++) send_frame(1, i, 192, 0);
    join
    repeat (3) @(negedge clk);
    gap_chk = 1'b0;
    chk("fair_frames", 64'(tdest_log.size()), 64'd20);
    for (int i = 0; i < tdest_log.size(); i++)
      chk($sformatf("fair_tdest%0d", i), 64'(tdest_log[i]), 64'(i % 2));
    chk("fair_cnt0", 64'(cnt0), 64'd10);
    chk("fair_cnt1", 64'(cnt1), 64'd10);
    chk("fair_idle_busy", 64'(busy), 64'd0);

    // Enable mask: port 1 held off until enabled
    cfg_en = 2'b01;
    tdest_log.delete();
    fork
      send_frame(0, 100, 128, 0);
      send_frame(1, 101, 64, 0);
      begin
        repeat (8) begin
          @(negedge clk); #2;
          chk("mask_rdy1", 64'(s_ready[1]), 64'd0);
        end
        chk("mask_cnt1_held", 64'(cnt1), 64'd10);
        chk("mask_busy_idle", 64'(busy), 64'd0);
        @(negedge clk);
        cfg_en = 2'b11;
      end
    join
    repeat (3) @(negedge clk);
    chk("mask_frames", 64'(tdest_log.size()), 64'd2);
    if (tdest_log.size() == 2) begin
      chk("mask_first", 64'(tdest_log[0]), 64'd0);
      chk("mask_second", 64'(tdest_log[1]), 64'd1);
    end
    chk("mask_cnt0", 64'(cnt0), 64'd11);
    chk("mask_cnt1", 64'(cnt1), 64'd11);

    // Clear enable[0] on beat 2 of a 4-beat port-0 frame
    tdest_log.delete();
    fork
      begin
        send_frame(0, 200, 256, 0);
        send_frame(0, 201, 64, 0);
      end
      send_frame(1, 202, 64, 0);
      begin
        wait_hs(1);
        @(negedge clk);
        cfg_en = 2'b10;
        wait_cnt1(12);
        chk("midmask_cnt0", 64'(cnt0), 64'd12);
        @(negedge clk);
        cfg_en = 2'b11;
      end
    join
    repeat (3) @(negedge clk);
    chk("midmask_frames", 64'(tdest_log.size()), 64'd3);
    if (tdest_log.size() == 3) begin
      chk("midmask_seq0", 64'(tdest_log[0]), 64'd0);
      chk("midmask_seq1", 64'(tdest_log[1]), 64'd1);
      chk("midmask_seq2", 64'(tdest_log[2]), 64'd0);
    end
    chk("midmask_cnt0_end", 64'(cnt0), 64'd13);
    chk("midmask_q0", 64'(exp_q0.size()), 64'd0);

    // Backpressure and source gaps on 64..1500-byte frames
    rdy_rand = 1'b1;
    fork
      begin
        send_frame(0, 300, 64, 30);  send_frame(0, 301, 1500, 30);
        send_frame(0, 302, 200, 30); send_frame(0, 303, 777, 30);
      end
      begin
        send_frame(1, 310, 1500, 30); send_frame(1, 311, 64, 30);
        send_frame(1, 312, 513, 30);  send_frame(1, 313, 128, 30);
      end
    join
    rdy_rand = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_cnt0", 64'(cnt0), 64'd17);
    chk("bp_cnt1", 64'(cnt1), 64'd16);
    chk("bp_q0", 64'(exp_q0.size()), 64'd0);
    chk("bp_q1", 64'(exp_q1.size()), 64'd0);

    // Counter wrap on the 2-bit instance: one single-beat frame every 2 cycles
    w_valid = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("wrap_cnt_3", 64'(w_cnt1), 64'd3);
    repeat (2) @(negedge clk);
    #1;
    chk("wrap_cnt_0", 64'(w_cnt1), 64'd0);
    chk("wrap_cnt0_idle", 64'(w_cnt0), 64'd0);
    w_valid = 1'b0;

    // Asynchronous reset in the middle of a 6-beat frame
    fork
      send_frame(0, 400, 384, 0);
      begin
        wait_hs(2);
        @(negedge clk);
        #2;
        chk("pre_rst_valid", 64'(m_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 64'(m_valid), 64'd0);
        chk("arst_busy",    64'(busy),    64'd0);
        chk("arst_rdy0",    64'(s_ready[0]), 64'd0);
        chk("arst_cnt0",    64'(cnt0), 64'd0);
        abort = 1'b1;
      end
    join
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    abort = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kugelblitz_offload_arb.md
# kugelblitz_offload_arb

Packet-level round-robin arbiter that shares one kugelblitz offload datapath between two AXI-stream requesters, for example the qsfp0 and qsfp1 TX streams, in a single clock domain. It grants the shared output to one input for a whole frame and tags each frame with its source on `m_axis_tdest`. It applies a per-port enable mask and counts forwarded frames per port. It sits directly in front of the offload engine and is configured from the block's AXI-lite register file.

## Interface
- `DATA_WIDTH`, 512, stream data width in bits.
- `KEEP_WIDTH`, `DATA_WIDTH/8`, tkeep width.
- `USER_WIDTH`, 1, tuser width.
- `CNT_WIDTH`, 32, per-port frame counter width.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s0_axis_tdata/tkeep/tvalid/tready/tlast/tuser`  in (tready out)  DATA/KEEP/1/1/1/USER  requester 0.
- `s1_axis_tdata/tkeep/tvalid/tready/tlast/tuser`  in (tready out)  same widths  requester 1.
- `m_axis_tdata/tkeep/tvalid/tready/tlast/tuser`  out (tready in)  same widths  to the offload engine.
- `m_axis_tdest`  out  1  index of the granted source.
- `cfg_enable`  in  2  per-port enable; bit i gates new grants to port i.
- `busy`  out  1  high while a frame is in flight.
- `pkt_count0`, `pkt_count1`  out  CNT_WIDTH  frames forwarded per port.

## Operation
- FSM states: IDLE, GRANT.
- **IDLE:**
  - The eligible request vector is req[i] = `si_axis_tvalid & cfg_enable[i]`.
  - If any request is asserted, select the winner by round-robin: the port not equal to `last_grant` has priority; if only one port requests, it wins.
  - Register `grant` := winner and `last_grant` := winner, then enter GRANT.
  - No transfer occurs in IDLE. All `si_axis_tready` are 0 and `m_axis_tvalid` is 0.
- **GRANT:**
  - Combinational passthrough from the granted port: `m_axis_tdata/tkeep/tlast/tuser/tvalid` = `s[grant]`, and `m_axis_tdest` = `grant`.
  - `s[grant]_axis_tready` = `m_axis_tready`. The other port's tready is 0.
  - On a beat where `m_axis_tvalid & m_axis_tready & m_axis_tlast`: increment `pkt_count[grant]` and return to IDLE.
- The enable mask is sampled only in IDLE. Clearing `cfg_enable[grant]` mid-frame does not truncate the frame; the frame completes normally.
- A frame is never interleaved or split. Gaps with `tvalid` low mid-frame hold the grant indefinitely.
- Counters are CNT_WIDTH unsigned and wrap from all-ones to 0. They are not cleared by `cfg_enable`.
- `busy` = (state == GRANT).
- Non-granted inputs are stalled and never dropped.

## Timing
- **Reset:**
  - On `rst_n` low, immediately and asynchronously: state = IDLE, `grant` = 0, `last_grant` = 1 (so port 0 wins the first tie), counters = 0.
  - All treadies = 0, `m_axis_tvalid` = 0, `m_axis_tdest` = 0, `busy` = 0.
  - Deassertion is taken synchronously by the surrounding reset synchronizer.
- **Reset mid-frame:** the in-flight frame is abandoned. The downstream engine sees `tvalid` drop without `tlast`; the offload engine must be reset together with this block.
- **Arbitration latency:** 1 cycle. A request seen in IDLE at cycle N makes data available on `m_axis` at cycle N+1.
- **Inter-frame gap:** exactly 1 idle cycle between frames, including back-to-back frames from alternating ports.
- **Datapath:** zero-latency combinational passthrough during GRANT. `m_axis_tready` is a combinational path to `s[grant]_axis_tready`.
- **Simultaneous events:**
  - Both ports requesting in IDLE: the winner is the port opposite `last_grant`.
  - `tlast` handshake and a new request in the same cycle: the new request is evaluated in the following IDLE cycle.
- **Single-beat frame** (`tlast` on the first beat): GRANT lasts 1 cycle if `m_axis_tready` is high, and the counter increments at the end of that cycle.

## Test plan
- **Reset defaults:** hold `rst_n` low → all outputs 0, both counters 0. Release, then present frames on both ports in the same cycle → port 0 is granted first, `m_axis_tdest`=0.
- **Fairness:** both ports continuously offer 3-beat frames for 10 frames each → output tdest sequence alternates 0,1,0,1…, with 1 idle cycle between frames; final `pkt_count0`=`pkt_count1`=10.
- **Enable mask:** `cfg_enable`=2'b01 with both ports requesting → only port 0 is granted and port 1 tready stays 0. Set enable to 2'b11 → port 1 is granted on the next arbitration.
- **Mask change mid-frame:** clear `cfg_enable[0]` during beat 2 of a 4-beat port-0 frame → all 4 beats are delivered with `tlast`, `pkt_count0` increments by 1, and the next grant goes to port 1.
- **Backpressure and gaps:** randomize `m_axis_tready` and source `tvalid` gaps on 64-byte to 1500-byte frames → output data/keep/user match input byte-for-byte per port, with no interleaving and no loss.
- **Counter wrap and async reset:**
  - Preload a counter near its maximum (force to 32'hFFFF_FFFF) and send one frame → the counter reads 0.
  - Assert `rst_n` low mid-frame → `m_axis_tvalid` drops in the same cycle and `busy`=0.
